lsu: RTL and testbench

//  Load/store stage directly downstream of exe. Accepts one exe result per transaction.
//  Mem ops issue one request on a valid/ready data-memory port, wait for the response,

---
 rtl/lsu.sv | 165 ++++++++++++++++
 tb/tb_lsu.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store stage: issues one data-memory request per ld/st packet, aligns and extends
// load data, and hands a single writeback packet downstream. One transaction in flight.
module lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [XLEN-1:0]   in_res,
  input  logic [XLEN-1:0]   in_st_data,
  input  logic              in_ld,
  input  logic              in_st,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [4:0]        in_rd,
  input  logic              in_wen,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [31:0]       mem_rsp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic [XLEN-1:0]   out_data,
  output logic              out_exc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Shift the addressed lane down to bit 0, then truncate and extend to the access size.
  function automatic logic [XLEN-1:0] f_load_ext(input logic [31:0] rdata,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
    logic [31:0] s;
    s = rdata >> {off, 3'b000};
    case (size)
      2'd0:    f_load_ext = uns ? {{(XLEN-8){1'b0}}, s[7:0]}   : {{(XLEN-8){s[7]}}, s[7:0]};
      2'd1:    f_load_ext = uns ? {{(XLEN-16){1'b0}}, s[15:0]} : {{(XLEN-16){s[15]}}, s[15:0]};
      default: f_load_ext = s;
    endcase
  endfunction

  function automatic logic [3:0] f_store_mask(input logic [1:0] off, input logic [1:0] size);
    case (size)
      2'd0:    f_store_mask = 4'b0001 << off;
      2'd1:    f_store_mask = 4'b0011 << off;
      default: f_store_mask = 4'b1111;
    endcase
  endfunction

  logic [1:0]        r_state;
  logic [31:0]       r_pc;
  logic [4:0]        r_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_ld;
  logic              r_st;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wmask;
  logic              r_wen;
  logic              r_exc;
  logic [XLEN-1:0]   r_data;

  logic w_mem;
  logic w_misalign;
  logic w_exc;

  assign w_mem      = in_ld | in_st;
  assign w_misalign = (in_size == 2'd3) ||
                      ((in_size == 2'd1) && in_res[0]) ||
                      ((in_size == 2'd2) && (in_res[1:0] != 2'b00));
  assign w_exc      = (in_ld & in_st) | (w_mem & w_misalign);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_rd       <= '0;
      r_addr     <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_ld       <= 1'b0;
      r_st       <= 1'b0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_wen      <= 1'b0;
      r_exc      <= 1'b0;
      r_data     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_pc       <= in_pc;
            r_rd       <= in_rd;
            r_addr     <= in_res[ADDR_W-1:0];
            r_size     <= in_size;
            r_unsigned <= in_unsigned;
            r_ld       <= in_ld;
            r_st       <= in_st;
            r_wdata    <= in_st_data << {in_res[1:0], 3'b000};
            r_wmask    <= in_st ? f_store_mask(in_res[1:0], in_size) : 4'b0000;
            if (!w_mem) begin
              r_data  <= in_res;
              r_wen   <= in_wen;
              r_exc   <= 1'b0;
              r_state <= S_DONE;
            end else if (w_exc) begin
              r_data  <= '0;
              r_wen   <= 1'b0;
              r_exc   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_data  <= '0;
              r_wen   <= in_wen & ~in_st;
              r_exc   <= 1'b0;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) r_state <= S_RESP;
        end
        S_RESP: begin
          if (mem_rsp_valid) begin
            r_data  <= r_ld ? f_load_ext(mem_rsp_rdata, r_addr[1:0], r_size, r_unsigned) : '0;
            r_state <= S_DONE;
          end
        end
        default: begin
          if (out_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = (r_state == S_IDLE);
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_req_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_req_wen   = r_st;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;
  assign mem_rsp_ready = (r_state == S_RESP);
  assign out_valid     = (r_state == S_DONE);
  assign out_pc        = r_pc;
  assign out_rd        = r_rd;
  assign out_wen       = r_wen;
  assign out_data      = r_data;
  assign out_exc       = r_exc;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: pass-through, loads, stores, exceptions, stalls and reset abort.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_res;
  logic [31:0] in_st_data;
  logic        in_ld;
  logic        in_st;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [31:0] out_data;
  logic        out_exc;

  int n_vec;
  int n_err;

  lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_res(in_res),
    .in_st_data(in_st_data), .in_ld(in_ld), .in_st(in_st), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_rd(in_rd), .in_wen(in_wen),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_wen(out_wen), .out_data(out_data), .out_exc(out_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input logic [31:0] pc, input logic [31:0] res, input logic [31:0] sd,
                           input logic ld, input logic st, input logic [1:0] size,
                           input logic uns, input logic [4:0] rd, input logic wen);
    in_valid = 1'b1; in_pc = pc; in_res = res; in_st_data = sd; in_ld = ld; in_st = st;
    in_size = size; in_unsigned = uns; in_rd = rd; in_wen = wen;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got %b want 0", mem_req_valid); end
    n_vec++; if ({out_data, out_pc} !== 64'h0) begin n_err++; $display("FAIL rst_out_regs got %h want 0", {out_data, out_pc}); end
    rst = 1'b0;
    step;
  endtask

  task automatic test_passthru;
    drive_pkt(32'h0000_0100, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd5, 1'b1);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pt_in_ready got %b want 1", in_ready); end
    step;
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pt_out_valid got %b want 1", out_valid); end
    n_vec++; if (out_data !== 32'h0000_1234) begin n_err++; $display("FAIL pt_data got %h want 00001234", out_data); end
    n_vec++; if ({out_wen, out_exc, out_rd} !== {1'b1, 1'b0, 5'd5}) begin n_err++; $display("FAIL pt_wen_exc_rd got %b want 1000101", {out_wen, out_exc, out_rd}); end
    n_vec++; if (out_pc !== 32'h0000_0100) begin n_err++; $display("FAIL pt_pc got %h want 00000100", out_pc); end
    step;
  endtask

  task automatic test_load;
    logic [31:0] addr_t [4];
    logic [31:0] rd_t   [4];
    logic [1:0]  sz_t   [4];
    logic        uns_t  [4];
    logic [31:0] exp_t  [4];
    addr_t = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h0000_0100};
    rd_t   = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_1234, 32'hDEAD_BEEF};
    sz_t   = '{2'd0, 2'd0, 2'd1, 2'd2};
    uns_t  = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp_t  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'hDEAD_BEEF};
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_rdata = rd_t[i];
      drive_pkt(32'h0000_0200, addr_t[i], 32'h0, 1'b1, 1'b0, sz_t[i], uns_t[i], 5'd7, 1'b1);
      step;
      in_valid = 1'b0;
      n_vec++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL ld%0d_req_valid got %b want 1", i, mem_req_valid); end
      n_vec++; if (mem_req_addr !== {addr_t[i][31:2], 2'b00}) begin n_err++; $display("FAIL ld%0d_addr got %h want %h", i, mem_req_addr, {addr_t[i][31:2], 2'b00}); end
      n_vec++; if ({mem_req_wen, mem_req_wmask} !== 5'b0) begin n_err++; $display("FAIL ld%0d_wen_mask got %b want 00000", i, {mem_req_wen, mem_req_wmask}); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ld%0d_in_ready got %b want 0", i, in_ready); end
      step;
      n_vec++; if ({mem_rsp_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL ld%0d_resp_state got %b want 10", i, {mem_rsp_ready, out_valid}); end
      step;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ld%0d_out_valid got %b want 1", i, out_valid); end
      n_vec++; if (out_data !== exp_t[i]) begin n_err++; $display("FAIL ld%0d_data got %h want %h", i, out_data, exp_t[i]); end
      n_vec++; if ({out_wen, out_exc} !== 2'b10) begin n_err++; $display("FAIL ld%0d_wen_exc got %b want 10", i, {out_wen, out_exc}); end
      step;
    end
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_store;
    logic [31:0] addr_t [2];
    logic [31:0] sd_t   [2];
    logic [1:0]  sz_t   [2];
    logic [31:0] wd_t   [2];
    logic [3:0]  wm_t   [2];
    addr_t = '{32'h8000_0002, 32'h8000_0011};
    sd_t   = '{32'h0000_ABCD, 32'h1234_5678};
    sz_t   = '{2'd1, 2'd0};
    wd_t   = '{32'hABCD_0000, 32'h3456_7800};
    wm_t   = '{4'b1100, 4'b0010};
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_pkt(32'h0000_0300, addr_t[i], sd_t[i], 1'b0, 1'b1, sz_t[i], 1'b0, 5'd3, 1'b1);
      step;
      in_valid = 1'b0;
      n_vec++; if (mem_req_wen !== 1'b1) begin n_err++; $display("FAIL st%0d_wen got %b want 1", i, mem_req_wen); end
      n_vec++; if (mem_req_wdata !== wd_t[i]) begin n_err++; $display("FAIL st%0d_wdata got %h want %h", i, mem_req_wdata, wd_t[i]); end
      n_vec++; if (mem_req_wmask !== wm_t[i]) begin n_err++; $display("FAIL st%0d_wmask got %b want %b", i, mem_req_wmask, wm_t[i]); end
      n_vec++; if (mem_req_addr !== {addr_t[i][31:2], 2'b00}) begin n_err++; $display("FAIL st%0d_addr got %h want %h", i, mem_req_addr, {addr_t[i][31:2], 2'b00}); end
      step; step;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL st%0d_out_valid got %b want 1", i, out_valid); end
      n_vec++; if ({out_wen, out_exc, out_data} !== 34'h0) begin n_err++; $display("FAIL st%0d_out got %h want 0", i, {out_wen, out_exc, out_data}); end
      step;
    end
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_exception;
    logic [31:0] addr_t [4];
    logic        ld_t   [4];
    logic        st_t   [4];
    logic [1:0]  sz_t   [4];
    addr_t = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000};
    ld_t   = '{1'b1, 1'b1, 1'b1, 1'b0};
    st_t   = '{1'b0, 1'b1, 1'b0, 1'b1};
    sz_t   = '{2'd2, 2'd2, 2'd1, 2'd3};
    mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_pkt(32'h0000_0400, addr_t[i], 32'hFFFF_FFFF, ld_t[i], st_t[i], sz_t[i], 1'b0, 5'd9, 1'b1);
      step;
      in_valid = 1'b0;
      n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL exc%0d_req_valid got %b want 0", i, mem_req_valid); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL exc%0d_out_valid got %b want 1", i, out_valid); end
      n_vec++; if ({out_exc, out_wen} !== 2'b10) begin n_err++; $display("FAIL exc%0d_exc_wen got %b want 10", i, {out_exc, out_wen}); end
      step;
      n_vec++; if ({mem_req_valid, out_valid, in_ready} !== 3'b001) begin n_err++; $display("FAIL exc%0d_after got %b want 001", i, {mem_req_valid, out_valid, in_ready}); end
    end
  endtask

  task automatic test_back_to_back;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    out_ready     = 1'b0;
    drive_pkt(32'h0000_0500, 32'h0000_0040, 32'h1122_3344, 1'b0, 1'b1, 2'd2, 1'b0, 5'd1, 1'b1);
    step;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if ({mem_req_valid, in_ready, mem_req_wen} !== 3'b101) begin n_err++; $display("FAIL stall_req%0d_ctl got %b want 101", i, {mem_req_valid, in_ready, mem_req_wen}); end
      n_vec++; if ({mem_req_addr, mem_req_wdata, mem_req_wmask} !== {32'h0000_0040, 32'h1122_3344, 4'b1111}) begin n_err++; $display("FAIL stall_req%0d_fields got %h %h %b", i, mem_req_addr, mem_req_wdata, mem_req_wmask); end
      step;
    end
    mem_req_ready = 1'b1;
    step;
    mem_req_ready = 1'b0;
    n_vec++; if ({mem_req_valid, mem_rsp_ready} !== 2'b01) begin n_err++; $display("FAIL stall_resp got %b want 01", {mem_req_valid, mem_rsp_ready}); end
    step;
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_vec++; if ({out_valid, in_ready, out_wen} !== 3'b100) begin n_err++; $display("FAIL stall_out%0d_ctl got %b want 100", i, {out_valid, in_ready, out_wen}); end
      n_vec++; if ({out_pc, out_rd} !== {32'h0000_0500, 5'd1}) begin n_err++; $display("FAIL stall_out%0d_fields got %h %0d", i, out_pc, out_rd); end
      step;
    end
    out_ready = 1'b1;
    drive_pkt(32'h0000_0600, 32'h0000_0055, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd2, 1'b1);
    step;
    n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL handoff_no_accept got %b want 01", {out_valid, in_ready}); end
    step;
    in_valid = 1'b0;
    n_vec++; if ({out_valid, out_data, out_pc} !== {1'b1, 32'h0000_0055, 32'h0000_0600}) begin n_err++; $display("FAIL b2b_second got %b %h %h", out_valid, out_data, out_pc); end
    step;
  endtask

  task automatic test_reset_abort;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    drive_pkt(32'h0000_0700, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd4, 1'b1);
    step;
    in_valid = 1'b0;
    step;
    n_vec++; if (mem_rsp_ready !== 1'b1) begin n_err++; $display("FAIL abort_in_resp got %b want 1", mem_rsp_ready); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    n_vec++; if ({in_ready, mem_req_valid, mem_rsp_ready, out_valid} !== 4'b1000) begin n_err++; $display("FAIL abort_idle got %b want 1000", {in_ready, mem_req_valid, mem_rsp_ready, out_valid}); end
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      step;
      n_vec++; if ({out_valid, mem_rsp_ready, in_ready} !== 3'b001) begin n_err++; $display("FAIL late_rsp%0d got %b want 001", i, {out_valid, mem_rsp_ready, in_ready}); end
    end
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_res = '0; in_st_data = '0; in_ld = 1'b0; in_st = 1'b0;
    in_size = '0; in_unsigned = 1'b0; in_rd = '0; in_wen = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; out_ready = 1'b1;
    #1;
    test_reset;
    test_passthru;
    test_load;
    test_store;
    test_exception;
    test_back_to_back;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
